// File: rtl/bus_arbiter_procesador.sv
// Two-master round-robin bus arbiter with lock, hold limit and slave-ready stretch.
// M0 is the processor load/store port; M1 is the program loader / DMA engine.
module bus_arbiter_procesador #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              m0_req_i,
    input  logic              m0_lock_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_lock_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic              bus_we_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ready_i
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StOwnM0 = 2'd1;
    localparam logic [1:0] StOwnM1 = 2'd2;

    localparam int unsigned      HoldW   = $clog2(MAX_HOLD) + 1;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;      // 0: M0 granted last, 1: M1 granted last
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

    logic own_m0, own_m1;
    logic own_req, own_lock, oth_req;
    logic beat_ack, release_bus;

    always_comb begin
        own_m0   = (state_q == StOwnM0);
        own_m1   = (state_q == StOwnM1);
        own_req  = (own_m0 & m0_req_i)  | (own_m1 & m1_req_i);
        own_lock = (own_m0 & m0_lock_i) | (own_m1 & m1_lock_i);
        oth_req  = (own_m0 & m1_req_i)  | (own_m1 & m0_req_i);
        beat_ack = own_req & bus_ready_i;
        // Dropping req before the ack is an abort and frees the bus just like an unlocked beat.
        release_bus = ~own_req |
                      (beat_ack & (~own_lock | (oth_req & (hold_cnt_q == HoldMax))));
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            StIdle: begin
                if (m0_req_i && (!m1_req_i || last_q)) begin
                    state_d = StOwnM0;
                end else if (m1_req_i) begin
                    state_d = StOwnM1;
                end
            end
            StOwnM0, StOwnM1: begin
                if (release_bus) begin
                    if (oth_req) begin
                        state_d = own_m0 ? StOwnM1 : StOwnM0;
                    end else if (!own_req) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StOwnM0) begin
            last_d = 1'b0;
        end else if (state_d == StOwnM1) begin
            last_d = 1'b1;
        end

        if ((state_d != state_q) || !oth_req) begin
            hold_cnt_d = '0;
        end else if (beat_ack && (hold_cnt_q != HoldMax)) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        m0_gnt_o    = own_m0;
        m1_gnt_o    = own_m1;
        m0_ack_o    = own_m0 & m0_req_i & bus_ready_i;
        m1_ack_o    = own_m1 & m1_req_i & bus_ready_i;
        m0_rdata_o  = bus_rdata_i;
        m1_rdata_o  = bus_rdata_i;
        bus_we_o    = (own_m0 & m0_req_i & m0_we_i) | (own_m1 & m1_req_i & m1_we_i);
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        if (own_m0) begin
            bus_addr_o  = m0_addr_i;
            bus_wdata_o = m0_wdata_i;
        end else if (own_m1) begin
            bus_addr_o  = m1_addr_i;
            bus_wdata_o = m1_wdata_i;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_procesador.sv
// Bench for bus_arbiter_procesador: directed scenarios plus random traffic checked
// cycle by cycle against a rule-level model of ownership, alternation and hold limit.
module tb_bus_arbiter_procesador;

    localparam int MaxHold = 8;

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic        lock  [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready;
    logic [31:0] rdata;

    logic        m0_gnt, m0_ack, m1_gnt, m1_ack, bus_we;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: owner (-1 = nobody), last granted master, consecutive held beats.
    int own;
    int last;
    int hold;
    bit acked [2];

    logic [31:0] addr_tab [8] = '{32'h1000, 32'h1004, 32'h13F8, 32'h2000,
                                  32'h2004, 32'h2008, 32'h2010, 32'h203C};

    bus_arbiter_procesador #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_HOLD (MaxHold)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .m0_req_i    (req[0]),
        .m0_lock_i   (lock[0]),
        .m0_we_i     (we[0]),
        .m0_addr_i   (addr[0]),
        .m0_wdata_i  (wdata[0]),
        .m0_gnt_o    (m0_gnt),
        .m0_ack_o    (m0_ack),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (req[1]),
        .m1_lock_i   (lock[1]),
        .m1_we_i     (we[1]),
        .m1_addr_i   (addr[1]),
        .m1_wdata_i  (wdata[1]),
        .m1_gnt_o    (m1_gnt),
        .m1_ack_o    (m1_ack),
        .m1_rdata_o  (m1_rdata),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_we_o    (bus_we),
        .bus_rdata_i (rdata),
        .bus_ready_i (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            req[i]   = 1'b0;
            lock[i]  = 1'b0;
            we[i]    = 1'b0;
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
        end
        ready = 1'b0;
        rdata = 32'h0;
    endtask

    // Called at a falling edge; asserts reset, checks outputs drop at once, releases next falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_gnt0", m0_gnt, 1'b0);
        check_eq("rst_gnt1", m1_gnt, 1'b0);
        check_eq("rst_ack0", m0_ack, 1'b0);
        check_eq("rst_ack1", m1_ack, 1'b0);
        check_eq("rst_we", bus_we, 1'b0);
        check_eq("rst_addr", bus_addr, 32'h0);
        check_eq("rst_wdata", bus_wdata, 32'h0);
        own = -1;
        last = 1;
        hold = 0;
        acked[0] = 1'b0;
        acked[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called after inputs are set for this cycle; checks outputs, advances the model one edge.
    task automatic tick();
        int nxt;
        int h;
        bit rel;
        bit e_ack [2];
        bit e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        #2;
        e_ack[0] = (own == 0) && req[0] && ready;
        e_ack[1] = (own == 1) && req[1] && ready;
        e_we = 1'b0;
        e_addr = 32'h0;
        e_wdata = 32'h0;
        if (own >= 0) begin
            e_we = req[own] && we[own];
            e_addr = addr[own];
            e_wdata = wdata[own];
        end
        check_eq("gnt0", m0_gnt, own == 0);
        check_eq("gnt1", m1_gnt, own == 1);
        check_eq("ack0", m0_ack, e_ack[0]);
        check_eq("ack1", m1_ack, e_ack[1]);
        check_eq("bus_we", bus_we, e_we);
        check_eq("bus_addr", bus_addr, e_addr);
        check_eq("bus_wdata", bus_wdata, e_wdata);
        check_eq("rdata0", m0_rdata, rdata);
        check_eq("rdata1", m1_rdata, rdata);

        if (own < 0) begin
            if (req[0] && req[1]) nxt = 1 - last;
            else if (req[0]) nxt = 0;
            else if (req[1]) nxt = 1;
            else nxt = -1;
        end else begin
            rel = !req[own] ||
                  (ready && (!lock[own] || (req[1 - own] && hold == MaxHold - 1)));
            if (!rel) nxt = own;
            else if (req[1 - own]) nxt = 1 - own;
            else if (req[own]) nxt = own;
            else nxt = -1;
        end

        if (own < 0 || nxt != own) h = 0;
        else if (!req[1 - own]) h = 0;
        else if (req[own] && ready) h = (hold + 1 > MaxHold - 1) ? MaxHold - 1 : hold + 1;
        else h = hold;

        acked[0] = e_ack[0];
        acked[1] = e_ack[1];
        @(posedge clk);
        own = nxt;
        hold = h;
        if (nxt >= 0) last = nxt;
        @(negedge clk);
    endtask

    task automatic new_req(input int i);
        req[i]   = ($urandom_range(0, 2) != 0);
        we[i]    = $urandom_range(0, 1) != 0;
        addr[i]  = addr_tab[$urandom_range(0, 7)];
        wdata[i] = $urandom;
        lock[i]  = $urandom_range(0, 1) != 0;
    endtask

    initial begin
        int n_ack;
        rst_n = 1'b0;
        own = -1;
        last = 1;
        hold = 0;
        clear_inputs();
        @(negedge clk);
        do_reset();

        // Both request out of reset: M0 first, then M1 with no idle bubble.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1004; wdata[0] = 32'hCAFE_0001;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h2000;
        ready = 1'b1;
        tick();
        check_eq("a_gnt0", m0_gnt, 1'b1);
        check_eq("a_we", bus_we, 1'b1);
        check_eq("a_ack0", m0_ack, 1'b1);
        tick();
        req[0] = 1'b0;
        #1;
        check_eq("a_gnt1_nobubble", m1_gnt, 1'b1);
        tick();
        clear_inputs();
        do_reset();

        // UART stretch: three not-ready cycles then completion.
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h2010; wdata[1] = 32'h0000_0041;
        tick();
        for (int k = 0; k < 4; k++) begin
            ready = (k == 3);
            #1;
            check_eq("s_ack1", m1_ack, k == 3);
            check_eq("s_addr", bus_addr, 32'h2010);
            tick();
        end
        clear_inputs();
        do_reset();

        // Locked M0 burst against a waiting M1: exactly MaxHold beats.
        req[0] = 1'b1; lock[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1000;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h2004;
        ready = 1'b1;
        n_ack = 0;
        for (int k = 0; k < 30; k++) begin
            addr[0] = 32'h1000 + 32'(4 * n_ack);
            wdata[0] = $urandom;
            #1;
            if (m1_gnt) break;
            if (m0_ack) n_ack++;
            tick();
        end
        check_eq("l_acks", n_ack, MaxHold);
        check_eq("l_gnt1", m1_gnt, 1'b1);
        tick();
        clear_inputs();
        do_reset();

        // Abort: M1 drops req mid-stretch while M0 waits.
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h2008; wdata[1] = 32'h0000_007F;
        ready = 1'b0;
        tick();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h1000;
        tick();
        req[1] = 1'b0;
        #1;
        check_eq("ab_we", bus_we, 1'b0);
        check_eq("ab_ack1", m1_ack, 1'b0);
        tick();
        check_eq("ab_gnt0", m0_gnt, 1'b1);
        clear_inputs();
        do_reset();

        // Read path.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h2000;
        ready = 1'b1; rdata = 32'h0000_00A5;
        tick();
        check_eq("r_ack0", m0_ack, 1'b1);
        check_eq("r_rdata0", m0_rdata, 32'h0000_00A5);
        check_eq("r_we", bus_we, 1'b0);
        clear_inputs();

        // Reset mid-beat, then M0 still wins first.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1008; ready = 1'b0;
        tick();
        tick();
        check_eq("mr_gnt0", m0_gnt, 1'b1);
        do_reset();
        req[1] = 1'b1; addr[1] = 32'h2004;
        tick();
        check_eq("mr_first", m0_gnt, 1'b1);
        clear_inputs();
        tick();
        do_reset();

        // Random traffic honouring the hold-until-ack protocol, with occasional aborts.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (req[i] && !acked[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else begin
                    new_req(i);
                end
            end
            ready = $urandom_range(0, 3) != 0;
            rdata = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
